// File: rtl/bitserial_alu_seq_if.sv
// Command/status interface between the array controller and bitserial_alu_seq.
//   master : controller side; drives start/op/src_a/src_b/dst/width, observes status.
//   slave  : sequencer side; receives the command, drives busy/done/carry_out/zero.
// Signals:
//   start      request, sampled only while the sequencer is idle
//   op         0=ADD 1=SUB 2=AND 3=OR 4=XOR 5..7=MOV(A)
//   src_a/b    LSB bit-column of operands A and B
//   dst        LSB bit-column of the result
//   width      field length in bits
//   busy/done  operation in progress / one-cycle completion pulse
//   carry_out  per-PE final carry, zero per-PE all-result-bits-zero flag
interface bitserial_alu_seq_if #(
    parameter int N_PE = 16,
    parameter int AW   = 10,
    parameter int WW   = 6
);
    logic            start;
    logic [2:0]      op;
    logic [AW-1:0]   src_a;
    logic [AW-1:0]   src_b;
    logic [AW-1:0]   dst;
    logic [WW-1:0]   width;
    logic            busy;
    logic            done;
    logic [N_PE-1:0] carry_out;
    logic [N_PE-1:0] zero;

    modport master (
        output start, op, src_a, src_b, dst, width,
        input  busy, done, carry_out, zero
    );

    modport slave (
        input  start, op, src_a, src_b, dst, width,
        output busy, done, carry_out, zero
    );
endinterface

// File: rtl/bitserial_alu_seq.sv
// Bit-serial arithmetic sequencer in front of a bit-sliced block RAM (one bit per PE
// per column). Walks a multi-bit field LSB-first: READ fetches the operand columns,
// WRITE combines them per PE (with a per-PE carry) and writes the result column.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   bus (slave)           start/op/src_a/src_b/dst/width in; busy/done/carry_out/zero out
//   wea, addra, dia       RAM port A: reads operand A; never written (dia = 0)
//   web, addrb, dib       RAM port B: reads operand B in READ, writes result in WRITE
//   doa, dob              RAM read data, valid one cycle after the address
//
// Optional build macro CARRY_WB_EN: for ADD/SUB, one extra CWB cycle writes the final
// carry column to dst+width. Undefined by default (carry only on carry_out).
module bitserial_alu_seq #(
    parameter int N_PE = 16,
    parameter int AW   = 10,
    parameter int WW   = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    bitserial_alu_seq_if.slave   bus,
    output logic                 wea,
    output logic                 web,
    output logic [AW-1:0]        addra,
    output logic [AW-1:0]        addrb,
    output logic [N_PE-1:0]      dia,
    output logic [N_PE-1:0]      dib,
    input  logic [N_PE-1:0]      doa,
    input  logic [N_PE-1:0]      dob
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRead  = 3'd1;
    localparam logic [2:0] StWrite = 3'd2;
    localparam logic [2:0] StDone  = 3'd3;
`ifdef CARRY_WB_EN
    localparam logic [2:0] StCwb   = 3'd4;
`endif

    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpAnd = 3'd2;
    localparam logic [2:0] OpOr  = 3'd3;
    localparam logic [2:0] OpXor = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [AW-1:0]   a_ptr_q, a_ptr_d;
    logic [AW-1:0]   b_ptr_q, b_ptr_d;
    logic [AW-1:0]   d_ptr_q, d_ptr_d;
    logic [WW-1:0]   width_q, width_d;
    logic [WW-1:0]   cnt_q, cnt_d;
    logic [N_PE-1:0] carry_q, carry_d;
    logic [N_PE-1:0] zero_q, zero_d;

    logic [N_PE-1:0] opb;
    logic [N_PE-1:0] res;
    logic [N_PE-1:0] sum_carry;
    logic            is_arith;
    logic            last_bit;

    // Per-PE bit-slice datapath; SUB is A + ~B with carry seeded to 1.
    always_comb begin
        opb       = (op_q == OpSub) ? ~dob : dob;
        is_arith  = (op_q == OpAdd) || (op_q == OpSub);
        sum_carry = (doa & opb) | (carry_q & (doa ^ opb));
        case (op_q)
            OpAdd, OpSub: res = doa ^ opb ^ carry_q;
            OpAnd:        res = doa & dob;
            OpOr:         res = doa | dob;
            OpXor:        res = doa ^ dob;
            default:      res = doa;
        endcase
        last_bit = ({1'b0, cnt_q} + (WW + 1)'(1)) >= {1'b0, width_q};
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_ptr_d = a_ptr_q;
        b_ptr_d = b_ptr_q;
        d_ptr_d = d_ptr_q;
        width_d = width_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    zero_d = '1;
                    if (bus.width != '0) begin
                        op_d    = bus.op;
                        a_ptr_d = bus.src_a;
                        b_ptr_d = bus.src_b;
                        d_ptr_d = bus.dst;
                        width_d = bus.width;
                        cnt_d   = '0;
                        carry_d = {N_PE{bus.op == OpSub}};
                        state_d = StRead;
                    end else begin
                        carry_d = '0;
                        state_d = StDone;
                    end
                end
            end
            StRead: state_d = StWrite;
            StWrite: begin
                if (is_arith) carry_d = sum_carry;
                zero_d  = zero_q & ~res;
                a_ptr_d = a_ptr_q + AW'(1);
                b_ptr_d = b_ptr_q + AW'(1);
                d_ptr_d = d_ptr_q + AW'(1);
                cnt_d   = cnt_q + WW'(1);
                if (!last_bit) begin
                    state_d = StRead;
                end else begin
`ifdef CARRY_WB_EN
                    state_d = is_arith ? StCwb : StDone;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef CARRY_WB_EN
            StCwb: state_d = StDone;
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            a_ptr_q <= '0;
            b_ptr_q <= '0;
            d_ptr_q <= '0;
            width_q <= '0;
            cnt_q   <= '0;
            carry_q <= '0;
            zero_q  <= '1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_ptr_q <= a_ptr_d;
            b_ptr_q <= b_ptr_d;
            d_ptr_q <= d_ptr_d;
            width_q <= width_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    // RAM ports are decoded from the state; port B is shared between the B read and
    // the result write, which never happen in the same cycle.
    always_comb begin
        wea   = 1'b0;
        web   = 1'b0;
        addra = '0;
        addrb = '0;
        dia   = '0;
        dib   = '0;
        case (state_q)
            StRead: begin
                addra = a_ptr_q;
                addrb = b_ptr_q;
            end
            StWrite: begin
                web   = 1'b1;
                addrb = d_ptr_q;
                dib   = res;
            end
`ifdef CARRY_WB_EN
            // d_ptr has already advanced to dst+width here.
            StCwb: begin
                web   = 1'b1;
                addrb = d_ptr_q;
                dib   = carry_q;
            end
`endif
            default: ;
        endcase
    end

`ifdef CARRY_WB_EN
    assign bus.busy = (state_q == StRead) || (state_q == StWrite) || (state_q == StCwb);
`else
    assign bus.busy = (state_q == StRead) || (state_q == StWrite);
`endif
    assign bus.done      = (state_q == StDone);
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_bitserial_alu_seq.sv
module tb_bitserial_alu_seq;
    localparam int N_PE  = 16;
    localparam int AW    = 10;
    localparam int WW    = 6;
    localparam int DEPTH = 1 << AW;
`ifdef CARRY_WB_EN
    localparam int CWB = 1;
`else
    localparam int CWB = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bitserial_alu_seq_if #(.N_PE(N_PE), .AW(AW), .WW(WW)) bus ();

    logic            wea, web;
    logic [AW-1:0]   addra, addrb;
    logic [N_PE-1:0] dia, dib, doa, dob;

    bitserial_alu_seq #(.N_PE(N_PE), .AW(AW), .WW(WW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .wea   (wea),
        .web   (web),
        .addra (addra),
        .addrb (addrb),
        .dia   (dia),
        .dib   (dib),
        .doa   (doa),
        .dob   (dob)
    );

    // Dual-port bit-sliced RAM, read-first, 1-cycle registered read.
    logic [N_PE-1:0] mem    [DEPTH];
    logic [N_PE-1:0] shadow [DEPTH];
    always @(posedge clk) begin
        doa <= mem[addra];
        dob <= mem[addrb];
        if (wea === 1'b1) mem[addra] = dia;
        if (web === 1'b1) mem[addrb] = dib;
    end

    int web_cnt = 0, wea_cnt = 0, dia_bad = 0, done_cnt = 0;
    always @(negedge clk) begin
        if (web === 1'b1) web_cnt++;
        if (wea === 1'b1) wea_cnt++;
        if (dia !== '0) dia_bad++;
        if (bus.done === 1'b1) done_cnt++;
    end

    int errors = 0;
    int checks = 0;
    logic [N_PE-1:0] m_carry, m_zero;

    function automatic longint unsigned field(input bit from_mem, input int col, input int w,
                                              input int pe);
        longint unsigned v = 0;
        for (int i = 0; i < w; i++)
            v[i] = from_mem ? mem[(col + i) % DEPTH][pe] : shadow[(col + i) % DEPTH][pe];
        return v;
    endfunction

    task automatic put_field(input bit to_mem, input int col, input int w, input int pe,
                             input longint unsigned v);
        for (int i = 0; i < w; i++) begin
            shadow[(col + i) % DEPTH][pe] = v[i];
            if (to_mem) mem[(col + i) % DEPTH][pe] = v[i];
        end
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== shadow[i]) n++;
        return n;
    endfunction

    function automatic int exp_lat(input int op, input int w);
        if (w == 0) return 1;
        return 2 * w + 1 + ((op <= 1) ? CWB : 0);
    endfunction

    function automatic int exp_writes(input int op, input int w);
        if (w == 0) return 0;
        return w + ((op <= 1) ? CWB : 0);
    endfunction

    // Field-level reference: whole-number add/subtract/logic on each PE's field.
    task automatic model_op(input int op, input int sa, input int sb, input int d, input int w);
        longint unsigned a, b, s, r, mask;
        if (w == 0) begin
            m_carry = '0;
            m_zero  = '1;
            return;
        end
        mask = (64'd1 << w) - 64'd1;
        for (int pe = 0; pe < N_PE; pe++) begin
            a = field(1'b0, sa, w, pe);
            b = field(1'b0, sb, w, pe);
            case (op)
                0:       s = a + b;
                1:       s = a + ((~b) & mask) + 64'd1;
                2:       s = a & b;
                3:       s = a | b;
                4:       s = a ^ b;
                default: s = a;
            endcase
            r = s & mask;
            m_carry[pe] = (op <= 1) ? s[w] : 1'b0;
            m_zero[pe]  = (r == 0);
            put_field(1'b0, d, w, pe, r);
        end
        if (CWB == 1 && op <= 1) shadow[(d + w) % DEPTH] = m_carry;
    endtask

    task automatic run_op(input int op, input int sa, input int sb, input int d, input int w,
                          input int pulse_at, output int lat, output logic dn, output logic bz);
        @(negedge clk);
        bus.op    = 3'(op);
        bus.src_a = AW'(sa);
        bus.src_b = AW'(sb);
        bus.dst   = AW'(d);
        bus.width = WW'(w);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 300) begin
            bus.start = (lat == pulse_at);
            if (lat == pulse_at) begin
                bus.op    = 3'd4;
                bus.dst   = bus.dst + AW'(5);
                bus.width = 6'd3;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        dn = bus.done;
        bz = bus.busy;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.dst   = '0;
        bus.width = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]    = N_PE'($urandom);
            shadow[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if ({wea, web} !== 2'b00) begin errors++; $display("FAIL reset_we got=%b exp=00", {wea, web}); end
        checks++; if ({addra, addrb} !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", {addra, addrb}); end
        checks++; if ({dia, dib} !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", {dia, dib}); end
        checks++; if (bus.carry_out !== 16'h0000) begin errors++; $display("FAIL reset_carry got=%h exp=0000", bus.carry_out); end
        checks++; if (bus.zero !== 16'hFFFF) begin errors++; $display("FAIL reset_zero got=%h exp=ffff", bus.zero); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_add();
        int lat, w0; logic dn, bz;
        for (int pe = 0; pe < N_PE; pe++) begin
            put_field(1'b1, 100, 8, pe, longint'($urandom_range(0, 255)));
            put_field(1'b1, 200, 8, pe, longint'($urandom_range(0, 255)));
        end
        put_field(1'b1, 100, 8, 0, 64'h5A); put_field(1'b1, 200, 8, 0, 64'h33);
        put_field(1'b1, 100, 8, 1, 64'hFF); put_field(1'b1, 200, 8, 1, 64'h01);
        model_op(0, 100, 200, 300, 8);
        w0 = web_cnt;
        run_op(0, 100, 200, 300, 8, 0, lat, dn, bz);
        checks++; if (lat !== 17 + CWB) begin errors++; $display("FAIL add_latency got=%0d exp=%0d", lat, 17 + CWB); end
        checks++; if (field(1'b1, 300, 8, 0) !== 64'h8D) begin errors++; $display("FAIL add_pe0 got=%h exp=8d", field(1'b1, 300, 8, 0)); end
        checks++; if (field(1'b1, 300, 8, 1) !== 64'h00) begin errors++; $display("FAIL add_pe1 got=%h exp=00", field(1'b1, 300, 8, 1)); end
        checks++; if (bus.carry_out[1:0] !== 2'b10) begin errors++; $display("FAIL add_carry01 got=%b exp=10", bus.carry_out[1:0]); end
        checks++; if (bus.zero[1] !== 1'b1) begin errors++; $display("FAIL add_zero1 got=%b exp=1", bus.zero[1]); end
        checks++; if (bus.carry_out !== m_carry) begin errors++; $display("FAIL add_carry got=%h exp=%h", bus.carry_out, m_carry); end
        checks++; if (bus.zero !== m_zero) begin errors++; $display("FAIL add_zero got=%h exp=%h", bus.zero, m_zero); end
        checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL add_mem got=%0d bad columns exp=0", mem_diff()); end
        checks++; if (web_cnt - w0 !== exp_writes(0, 8)) begin errors++; $display("FAIL add_writes got=%0d exp=%0d", web_cnt - w0, exp_writes(0, 8)); end
        checks++; if ({dn, bz} !== 2'b00) begin errors++; $display("FAIL add_done_pulse got=%b exp=00", {dn, bz}); end
    endtask

    task automatic test_width0();
        int lat, w0; logic dn, bz;
        model_op(0, 10, 20, 30, 0);
        w0 = web_cnt;
        run_op(0, 10, 20, 30, 0, 0, lat, dn, bz);
        checks++; if (lat !== 1) begin errors++; $display("FAIL w0_latency got=%0d exp=1", lat); end
        checks++; if (web_cnt - w0 !== 0) begin errors++; $display("FAIL w0_writes got=%0d exp=0", web_cnt - w0); end
        checks++; if (bus.carry_out !== 16'h0000) begin errors++; $display("FAIL w0_carry got=%h exp=0000", bus.carry_out); end
        checks++; if (bus.zero !== 16'hFFFF) begin errors++; $display("FAIL w0_zero got=%h exp=ffff", bus.zero); end
        checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL w0_mem got=%0d bad columns exp=0", mem_diff()); end
    endtask

    task automatic test_sub();
        int lat; logic dn, bz;
        put_field(1'b1, 400, 4, 0, 64'd3); put_field(1'b1, 410, 4, 0, 64'd5);
        put_field(1'b1, 400, 4, 1, 64'd9); put_field(1'b1, 410, 4, 1, 64'd9);
        model_op(1, 400, 410, 420, 4);
        run_op(1, 400, 410, 420, 4, 0, lat, dn, bz);
        checks++; if (lat !== 9 + CWB) begin errors++; $display("FAIL sub_latency got=%0d exp=%0d", lat, 9 + CWB); end
        checks++; if (field(1'b1, 420, 4, 0) !== 64'hE) begin errors++; $display("FAIL sub_pe0 got=%h exp=e", field(1'b1, 420, 4, 0)); end
        checks++; if (field(1'b1, 420, 4, 1) !== 64'h0) begin errors++; $display("FAIL sub_pe1 got=%h exp=0", field(1'b1, 420, 4, 1)); end
        checks++; if ({bus.zero[1], bus.carry_out[1:0]} !== 3'b110) begin errors++; $display("FAIL sub_flags got=%b exp=110", {bus.zero[1], bus.carry_out[1:0]}); end
        checks++; if ({bus.carry_out, bus.zero} !== {m_carry, m_zero}) begin errors++; $display("FAIL sub_model_flags got=%h exp=%h", {bus.carry_out, bus.zero}, {m_carry, m_zero}); end
        checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL sub_mem got=%0d bad columns exp=0", mem_diff()); end
    endtask

    task automatic test_xor_wrap();
        int lat, w0; logic dn, bz;
        model_op(4, 1016, 500, 1016, 16);
        w0 = web_cnt;
        run_op(4, 1016, 500, 1016, 16, 0, lat, dn, bz);
        checks++; if (lat !== 33) begin errors++; $display("FAIL xor_latency got=%0d exp=33", lat); end
        checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL xor_wrap_mem got=%0d bad columns exp=0", mem_diff()); end
        checks++; if (bus.carry_out !== m_carry) begin errors++; $display("FAIL xor_carry got=%h exp=%h", bus.carry_out, m_carry); end
        checks++; if (bus.zero !== m_zero) begin errors++; $display("FAIL xor_zero got=%h exp=%h", bus.zero, m_zero); end
        checks++; if (web_cnt - w0 !== 16) begin errors++; $display("FAIL xor_writes got=%0d exp=16", web_cnt - w0); end
    endtask

    task automatic test_start_ignored();
        int lat; logic dn, bz;
        model_op(0, 600, 610, 620, 4);
        run_op(0, 600, 610, 620, 4, 3, lat, dn, bz);
        checks++; if (lat !== 9 + CWB) begin errors++; $display("FAIL ign_latency got=%0d exp=%0d", lat, 9 + CWB); end
        checks++; if ({dn, bz} !== 2'b00) begin errors++; $display("FAIL ign_restart got=%b exp=00", {dn, bz}); end
        checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL ign_mem got=%0d bad columns exp=0", mem_diff()); end
        checks++; if (bus.carry_out !== m_carry) begin errors++; $display("FAIL ign_carry got=%h exp=%h", bus.carry_out, m_carry); end
    endtask

    task automatic test_reset_midop();
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        bus.op = 3'd0; bus.src_a = 10'd700; bus.src_b = 10'd710; bus.dst = 10'd720;
        bus.width = 6'd8; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({bus.busy, web} !== 2'b00) begin errors++; $display("FAIL rst_mid_busy_web got=%b exp=00", {bus.busy, web}); end
        checks++; if (bus.zero !== 16'hFFFF) begin errors++; $display("FAIL rst_mid_zero got=%h exp=ffff", bus.zero); end
        checks++; if (bus.carry_out !== 16'h0000) begin errors++; $display("FAIL rst_mid_carry got=%h exp=0000", bus.carry_out); end
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rst_mid_done got=%0d pulses exp=0", done_cnt - d0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got=%b exp=0", bus.busy); end
        for (int i = 0; i < DEPTH; i++) shadow[i] = mem[i];
    endtask

    task automatic test_cwb();
        int lat; logic dn, bz;
        logic [N_PE-1:0] exp_col;
        for (int pe = 0; pe < N_PE; pe++) begin
            put_field(1'b1, 800, 4, pe, 64'hF);
            put_field(1'b1, 810, 4, pe, 64'h1);
        end
        mem[824] = '0; shadow[824] = '0;
        exp_col = (CWB == 1) ? 16'hFFFF : 16'h0000;
        model_op(0, 800, 810, 820, 4);
        run_op(0, 800, 810, 820, 4, 0, lat, dn, bz);
        checks++; if (lat !== 9 + CWB) begin errors++; $display("FAIL cwb_latency got=%0d exp=%0d", lat, 9 + CWB); end
        checks++; if (mem[824] !== exp_col) begin errors++; $display("FAIL cwb_column got=%h exp=%h", mem[824], exp_col); end
        checks++; if (bus.carry_out !== 16'hFFFF) begin errors++; $display("FAIL cwb_carry got=%h exp=ffff", bus.carry_out); end
        checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL cwb_mem got=%0d bad columns exp=0", mem_diff()); end
    endtask

    task automatic test_random();
        int lat, w0, op, w, base, sa, sb, d; logic dn, bz;
        for (int n = 0; n < 24; n++) begin
            op   = $urandom_range(0, 7);
            w    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
            base = $urandom_range(0, DEPTH - 1);
            sa   = base;
            sb   = ($urandom_range(0, 3) == 0) ? sa : (base + 256) % DEPTH;
            d    = (base + 512 + $urandom_range(0, 200)) % DEPTH;
            model_op(op, sa, sb, d, w);
            w0 = web_cnt;
            run_op(op, sa, sb, d, w, 0, lat, dn, bz);
            checks++; if (lat !== exp_lat(op, w)) begin errors++; $display("FAIL rnd%0d_latency op=%0d w=%0d got=%0d exp=%0d", n, op, w, lat, exp_lat(op, w)); end
            checks++; if (bus.carry_out !== m_carry) begin errors++; $display("FAIL rnd%0d_carry op=%0d w=%0d got=%h exp=%h", n, op, w, bus.carry_out, m_carry); end
            checks++; if (bus.zero !== m_zero) begin errors++; $display("FAIL rnd%0d_zero op=%0d w=%0d got=%h exp=%h", n, op, w, bus.zero, m_zero); end
            checks++; if (mem_diff() !== 0) begin errors++; $display("FAIL rnd%0d_mem op=%0d w=%0d got=%0d bad columns exp=0", n, op, w, mem_diff()); end
            checks++; if (web_cnt - w0 !== exp_writes(op, w)) begin errors++; $display("FAIL rnd%0d_writes got=%0d exp=%0d", n, web_cnt - w0, exp_writes(op, w)); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_width0();
        test_sub();
        test_xor_wrap();
        test_start_ignored();
        test_reset_midop();
        test_cwb();
        test_random();
        checks++; if (wea_cnt !== 0) begin errors++; $display("FAIL port_a_writes got=%0d exp=0", wea_cnt); end
        checks++; if (dia_bad !== 0) begin errors++; $display("FAIL dia_nonzero got=%0d cycles exp=0", dia_bad); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
